// File: rtl/rvh_l1d_amo_ctrl.sv
// L1D atomic memory operation sequencer: read old value, compute via L1D ALU, write back, return old value.
// Define RVH_L1D_AMO_MINMAX_EN to build MIN/MAX/MINU/MAXU; otherwise those ops respond with err.
//   state | meaning
//   IDLE  | ready for a request
//   RD    | bank read request pending
//   RW    | waiting for bank read data
//   EXE   | ALU driven from registers, new value latched
//   WR    | bank write pending
//   RESP  | response to LSU pending
module rvh_l1d_amo_ctrl #(
    parameter int XLEN         = 64,
    parameter int ALU_OP_WIDTH = 4,
    parameter int ID_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_vld_i,
    output logic                    req_rdy_o,
    input  logic [3:0]              req_amo_op_i,
    input  logic                    req_op_w_i,
    input  logic [ID_W-1:0]         req_id_i,
    input  logic [XLEN-1:0]         req_data_i,
    output logic                    rd_vld_o,
    input  logic                    rd_rdy_i,
    input  logic                    rd_resp_vld_i,
    input  logic [XLEN-1:0]         rd_resp_data_i,
    output logic [ALU_OP_WIDTH-1:0] alu_opcode_o,
    output logic                    alu_op_w_o,
    output logic [XLEN-1:0]         alu_operand0_o,
    output logic [XLEN-1:0]         alu_operand1_o,
    input  logic [XLEN-1:0]         alu_result_i,
    output logic                    wr_vld_o,
    input  logic                    wr_rdy_i,
    output logic [XLEN-1:0]         wr_data_o,
    output logic                    resp_vld_o,
    input  logic                    resp_rdy_i,
    output logic [ID_W-1:0]         resp_id_o,
    output logic [XLEN-1:0]         resp_data_o,
    output logic                    resp_err_o
);
    localparam logic [3:0] AMO_SWAP = 4'd0, AMO_ADD = 4'd1, AMO_XOR = 4'd2, AMO_AND = 4'd3,
                           AMO_OR = 4'd4, AMO_MIN = 4'd5, AMO_MAX = 4'd6, AMO_MINU = 4'd7,
                           AMO_MAXU = 4'd8;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(7);

    typedef enum logic [2:0] {IDLE, RD, RW, EXE, WR, RESP} state_t;

    state_t            state;
    logic [3:0]        op_q;
    logic              op_w_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   new_val;
    logic              zext;

    function automatic logic op_legal(input logic [3:0] op);
`ifdef RVH_L1D_AMO_MINMAX_EN
        return op <= AMO_MAXU;
`else
        return op <= AMO_OR;
`endif
    endfunction

    function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w,
                                              input logic zx);
        if (!w)
            return v;
        if (zx)
            return {{(XLEN-32){1'b0}}, v[31:0]};
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [ALU_OP_WIDTH-1:0] alu_op_map(input logic [3:0] op);
        case (op)
            AMO_XOR:            return ALU_XOR;
            AMO_AND:            return ALU_AND;
            AMO_OR:             return ALU_OR;
            AMO_MIN, AMO_MAX:   return ALU_SLT;
            AMO_MINU, AMO_MAXU: return ALU_SLTU;
            default:            return ALU_ADD;
        endcase
    endfunction

    assign zext = (op_q == AMO_MINU) || (op_q == AMO_MAXU);

    // For min/max the ALU only supplies the compare; the selected value comes from the operands.
    always_comb begin
        new_val = alu_result_i;
        case (op_q)
            AMO_SWAP:           new_val = rs2_q;
`ifdef RVH_L1D_AMO_MINMAX_EN
            AMO_MIN, AMO_MINU:  new_val = alu_result_i[0] ? alu_operand0_o : alu_operand1_o;
            AMO_MAX, AMO_MAXU:  new_val = alu_result_i[0] ? alu_operand1_o : alu_operand0_o;
`endif
            default:            new_val = alu_result_i;
        endcase
        if (op_w_q)
            new_val = {{(XLEN-32){1'b0}}, new_val[31:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            req_rdy_o      <= 1'b1;
            rd_vld_o       <= 1'b0;
            wr_vld_o       <= 1'b0;
            resp_vld_o     <= 1'b0;
            op_q           <= '0;
            op_w_q         <= 1'b0;
            rs2_q          <= '0;
            old_q          <= '0;
            alu_opcode_o   <= ALU_ADD;
            alu_op_w_o     <= 1'b0;
            alu_operand0_o <= '0;
            alu_operand1_o <= '0;
            wr_data_o      <= '0;
            resp_id_o      <= '0;
            resp_data_o    <= '0;
            resp_err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_vld_i) begin
                    req_rdy_o <= 1'b0;
                    op_q      <= req_amo_op_i;
                    op_w_q    <= req_op_w_i;
                    rs2_q     <= req_data_i;
                    resp_id_o <= req_id_i;
                    if (op_legal(req_amo_op_i)) begin
                        rd_vld_o   <= 1'b1;
                        resp_err_o <= 1'b0;
                        state      <= RD;
                    end else begin
                        resp_vld_o  <= 1'b1;
                        resp_err_o  <= 1'b1;
                        resp_data_o <= '0;
                        state       <= RESP;
                    end
                end
                RD: if (rd_rdy_i) begin
                    rd_vld_o <= 1'b0;
                    state    <= RW;
                end
                // ALU inputs are registered here so they are stable for the whole EXE cycle.
                RW: if (rd_resp_vld_i) begin
                    old_q          <= rd_resp_data_i;
                    alu_opcode_o   <= alu_op_map(op_q);
                    alu_op_w_o     <= (op_q == AMO_ADD) && op_w_q;
                    alu_operand0_o <= fmt_w(rd_resp_data_i, op_w_q, zext);
                    alu_operand1_o <= fmt_w(rs2_q, op_w_q, zext);
                    state          <= EXE;
                end
                EXE: begin
                    wr_data_o      <= new_val;
                    resp_data_o    <= fmt_w(old_q, op_w_q, 1'b0);
                    alu_opcode_o   <= ALU_ADD;
                    alu_op_w_o     <= 1'b0;
                    alu_operand0_o <= '0;
                    alu_operand1_o <= '0;
                    wr_vld_o       <= 1'b1;
                    state          <= WR;
                end
                WR: if (wr_rdy_i) begin
                    wr_vld_o   <= 1'b0;
                    resp_vld_o <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_rdy_i) begin
                    resp_vld_o <= 1'b0;
                    req_rdy_o  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// Randomized bench for rvh_l1d_amo_ctrl: acts as LSU, data bank and ALU, and checks against an AMO value model.
module tb_rvh_l1d_amo_ctrl;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
                           ALU_XOR = 4'd4, ALU_OR = 4'd6, ALU_AND = 4'd7;
`ifdef RVH_L1D_AMO_MINMAX_EN
    localparam int MAX_LEGAL = 8;
`else
    localparam int MAX_LEGAL = 4;
`endif

    logic        clk, rst;
    logic        req_vld_i, req_rdy_o, req_op_w_i;
    logic [3:0]  req_amo_op_i;
    logic [7:0]  req_id_i, resp_id_o;
    logic [63:0] req_data_i, rd_resp_data_i, alu_operand0_o, alu_operand1_o, alu_result_i;
    logic [63:0] wr_data_o, resp_data_o;
    logic        rd_vld_o, rd_rdy_i, rd_resp_vld_i, alu_op_w_o, wr_vld_o, wr_rdy_i;
    logic        resp_vld_o, resp_rdy_i, resp_err_o;
    logic [3:0]  alu_opcode_o;
    logic [63:0] add_r;

    int n_tot = 0;
    int n_bad = 0;

    rvh_l1d_amo_ctrl dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_amo_op_i(req_amo_op_i),
        .req_op_w_i(req_op_w_i), .req_id_i(req_id_i), .req_data_i(req_data_i),
        .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i), .rd_resp_vld_i(rd_resp_vld_i),
        .rd_resp_data_i(rd_resp_data_i),
        .alu_opcode_o(alu_opcode_o), .alu_op_w_o(alu_op_w_o),
        .alu_operand0_o(alu_operand0_o), .alu_operand1_o(alu_operand1_o),
        .alu_result_i(alu_result_i),
        .wr_vld_o(wr_vld_o), .wr_rdy_i(wr_rdy_i), .wr_data_o(wr_data_o),
        .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_id_o(resp_id_o),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural L1D ALU
    always_comb begin
        add_r = alu_operand0_o + alu_operand1_o;
        alu_result_i = 64'd0;
        case (alu_opcode_o)
            ALU_ADD:  alu_result_i = alu_op_w_o ? {{32{add_r[31]}}, add_r[31:0]} : add_r;
            ALU_SLT:  alu_result_i = {63'd0, $signed(alu_operand0_o) < $signed(alu_operand1_o)};
            ALU_SLTU: alu_result_i = {63'd0, alu_operand0_o < alu_operand1_o};
            ALU_XOR:  alu_result_i = alu_operand0_o ^ alu_operand1_o;
            ALU_OR:   alu_result_i = alu_operand0_o | alu_operand1_o;
            ALU_AND:  alu_result_i = alu_operand0_o & alu_operand1_o;
            default:  alu_result_i = 64'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        check("rst_req_rdy", req_rdy_o, 1);
        check("rst_valids", {rd_vld_o, wr_vld_o, resp_vld_o, resp_err_o}, 0);
        check("rst_wr_data", wr_data_o, 0);
        check("rst_resp_data", resp_data_o, 0);
        check("rst_resp_id", resp_id_o, 0);
        check("rst_alu_op", {alu_op_w_o, alu_opcode_o}, {1'b0, ALU_ADD});
        check("rst_alu_opnd", alu_operand0_o | alu_operand1_o, 0);
    endtask

    function automatic logic [63:0] sx32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 7));
            2:       return {32'h0, $urandom};
            default: return 64'd0 - 64'($urandom_range(1, 8));
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_amo(input logic [3:0] op, input logic w, input logic [7:0] id,
                           input logic [63:0] rs2, input logic [63:0] old,
                           input int rd_st, input int rs_dly, input int wr_st, input int rp_st,
                           input bit abort);
        logic        legal, uns, exp_rd, exp_wr, exp_rsp, exe, exp_opw;
        logic [63:0] a, b, exp_new, exp_resp;
        logic [3:0]  exp_opc;
        int          t_rdhs, t_pulse, t_wrhs, rd_cnt, wr_cnt, rp_cnt;
        bit          done, aborted;

        legal = (int'(op) <= MAX_LEGAL);
        uns   = (op == 4'd7) || (op == 4'd8);
        a = w ? (uns ? {32'h0, old[31:0]} : sx32(old)) : old;
        b = w ? (uns ? {32'h0, rs2[31:0]} : sx32(rs2)) : rs2;
        case (op)
            4'd0:    exp_new = rs2;
            4'd1:    exp_new = a + b;
            4'd2:    exp_new = a ^ b;
            4'd3:    exp_new = a & b;
            4'd4:    exp_new = a | b;
            4'd5:    exp_new = ($signed(a) < $signed(b)) ? a : b;
            4'd6:    exp_new = ($signed(a) < $signed(b)) ? b : a;
            4'd7:    exp_new = (a < b) ? a : b;
            4'd8:    exp_new = (a < b) ? b : a;
            default: exp_new = 64'd0;
        endcase
        if (w) exp_new = {32'h0, exp_new[31:0]};
        exp_resp = !legal ? 64'd0 : (w ? sx32(old) : old);
        case (op)
            4'd2:       exp_opc = ALU_XOR;
            4'd3:       exp_opc = ALU_AND;
            4'd4:       exp_opc = ALU_OR;
            4'd5, 4'd6: exp_opc = ALU_SLT;
            4'd7, 4'd8: exp_opc = ALU_SLTU;
            default:    exp_opc = ALU_ADD;
        endcase
        exp_opw = (op == 4'd1) && w;

        check("idle_rdy", req_rdy_o, 1);
        req_vld_i = 1'b1; req_amo_op_i = op; req_op_w_i = w; req_id_i = id; req_data_i = rs2;
        @(negedge clk);
        req_vld_i = 1'b0; req_amo_op_i = 4'($urandom); req_op_w_i = 1'($urandom);
        req_id_i = 8'($urandom); req_data_i = {$urandom, $urandom};
        t_rdhs = -1; t_pulse = -1; t_wrhs = -1; rd_cnt = 0; wr_cnt = 0; rp_cnt = 0;
        done = 0; aborted = 0;

        for (int t = 1; t < 120 && !done; t++) begin
            rd_rdy_i = 0; wr_rdy_i = 0; resp_rdy_i = 0; rd_resp_vld_i = 0;
            rd_resp_data_i = {$urandom, $urandom};
            exp_rd  = legal && t_rdhs < 0;
            exp_wr  = legal && t_pulse >= 0 && t >= t_pulse + 2 && t_wrhs < 0;
            exp_rsp = legal ? (t_wrhs >= 0) : 1'b1;
            exe     = legal && t_pulse >= 0 && t == t_pulse + 1;
            check("req_rdy_busy", req_rdy_o, 0);
            check("rd_vld", rd_vld_o, exp_rd);
            check("wr_vld", wr_vld_o, exp_wr);
            check("resp_vld", resp_vld_o, exp_rsp);
            if (exe) begin
                if (op != 4'd0) begin
                    check("exe_alu_op", {alu_op_w_o, alu_opcode_o}, {exp_opw, exp_opc});
                    check("exe_opnd0", alu_operand0_o, a);
                    check("exe_opnd1", alu_operand1_o, b);
                end
            end else begin
                check("alu_idle_op", {alu_op_w_o, alu_opcode_o}, {1'b0, ALU_ADD});
                check("alu_idle_opnd", alu_operand0_o | alu_operand1_o, 0);
            end
            if (exp_rd) begin
                if (rd_cnt >= rd_st) begin
                    rd_rdy_i = 1; t_rdhs = t; t_pulse = t + 1 + rs_dly;
                end else begin
                    rd_resp_vld_i = 1'($urandom_range(0, 1));
                end
                rd_cnt++;
            end
            if (t == t_pulse) begin
                rd_resp_vld_i = 1; rd_resp_data_i = old;
            end
            if (exp_wr) begin
                check("wr_data", wr_data_o, exp_new);
                if (abort) begin
                    rst = 1'b0;
                    #1 chk_reset();
                    @(negedge clk);
                    rst = 1'b1;
                    repeat (4) begin
                        @(negedge clk);
                        check("post_rst_vld", {wr_vld_o, resp_vld_o, rd_vld_o}, 0);
                        check("post_rst_rdy", req_rdy_o, 1);
                    end
                    aborted = 1; done = 1;
                end else if (wr_cnt >= wr_st) begin
                    wr_rdy_i = 1; t_wrhs = t;
                end else begin
                    rd_resp_vld_i = 1'($urandom_range(0, 1));
                end
                wr_cnt++;
            end
            if (exp_rsp) begin
                check("resp_id", resp_id_o, id);
                check("resp_data", resp_data_o, exp_resp);
                check("resp_err", resp_err_o, !legal);
                if (rp_cnt >= rp_st) begin
                    resp_rdy_i = 1; done = 1;
                end
                rp_cnt++;
            end
            if (!aborted) @(negedge clk);
        end
        check("completed", done, 1);
        rd_rdy_i = 0; wr_rdy_i = 0; resp_rdy_i = 0; rd_resp_vld_i = 0;
        if (!aborted) begin
            check("back_idle", req_rdy_o, 1);
            check("resp_drop", resp_vld_o, 0);
        end
    endtask

    initial begin
        logic [3:0] op;
        int r;
        rst = 1'b1;
        req_vld_i = 0; req_amo_op_i = 0; req_op_w_i = 0; req_id_i = 0; req_data_i = 0;
        rd_rdy_i = 0; rd_resp_vld_i = 0; rd_resp_data_i = 0; wr_rdy_i = 0; resp_rdy_i = 0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b1;
        @(negedge clk);
        chk_reset();

        run_amo(4'd1, 1'b0, 8'h11, 64'h3, 64'h5, 0, 0, 0, 0, 0);
        run_amo(4'd1, 1'b1, 8'h12, 64'h1, 64'h7FFF_FFFF, 0, 0, 0, 0, 0);
        run_amo(4'd1, 1'b1, 8'h13, 64'h1234, 64'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_amo(4'd5, 1'b0, 8'h14, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0);
        run_amo(4'd7, 1'b0, 8'h15, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0);
        run_amo(4'd0, 1'b0, 8'hA5, 64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF, 3, 0, 2, 4, 0);
        run_amo(4'd12, 1'b0, 8'h16, 64'h55, 64'h66, 0, 0, 0, 0, 0);
        run_amo(4'd1, 1'b0, 8'h17, 64'h9, 64'h10, 0, 0, 3, 0, 1);
        run_amo(4'd2, 1'b0, 8'h18, 64'hF0F0, 64'hFF00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            op = (r == 9) ? 4'($urandom_range(9, 15)) : 4'(r);
            run_amo(op, 1'($urandom), 8'($urandom), rnd64(), rnd64(),
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 3), 0);
            repeat ($urandom_range(0, 2)) begin
                rd_resp_vld_i = 1'($urandom);
                @(negedge clk);
                rd_resp_vld_i = 0;
                check("gap_rdy", req_rdy_o, 1);
                check("gap_vld", {rd_vld_o, wr_vld_o, resp_vld_o}, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/rvh_l1d_amo_ctrl.md
# rvh_l1d_amo_ctrl

Sequencer for atomic memory operations (AMO) in the L1 data cache. It accepts one AMO request from the LSU and reads the old value from the data bank. It drives the L1D ALU (operand0 = old memory value, operand1 = rs2 data) to compute the new value, writes that value back to the bank, and returns the old value to the LSU. It sits directly upstream of the L1D ALU and owns every operand and opcode that the ALU sees.

## Interface
- XLEN, 64, data width
- ALU_OP_WIDTH, 4, ALU opcode width (uop_encoding_pkg ALU_* values)
- ID_W, 8, request tag width
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_vld_i / req_rdy_o  in/out  1  AMO request handshake
- req_amo_op_i  in  4  0 SWAP, 1 ADD, 2 XOR, 3 AND, 4 OR, 5 MIN, 6 MAX, 7 MINU, 8 MAXU; 9–15 illegal
- req_op_w_i  in  1  word (.W) operation
- req_id_i  in  ID_W  tag, returned unchanged
- req_data_i  in  XLEN  rs2 value; for .W only bits [31:0] are used
- rd_vld_o / rd_rdy_i  out/in  1  bank read request handshake
- rd_resp_vld_i  in  1  read data valid, single-cycle pulse
- rd_resp_data_i  in  XLEN  old value, low-aligned for .W
- alu_opcode_o  out  ALU_OP_WIDTH  to ALU
- alu_op_w_o  out  1  to ALU
- alu_operand0_o, alu_operand1_o  out  XLEN  to ALU
- alu_result_i  in  XLEN  ALU result, combinational
- wr_vld_o / wr_rdy_i  out/in  1  bank write handshake
- wr_data_o  out  XLEN  new value; for .W, upper 32 bits are zero
- resp_vld_o / resp_rdy_i  out/in  1  LSU response handshake
- resp_id_o  out  ID_W  tag
- resp_data_o  out  XLEN  old value; for .W, sign-extended from bit 31
- resp_err_o  out  1  illegal or disabled opcode

## Operation
- FSM states: IDLE, RD, RW, EXE, WR, RESP. Reset state is IDLE.
- Transitions:
  - IDLE: req_rdy_o=1. A handshake latches op, w, id and data.
    - Legal op: go to RD.
    - Illegal op: go to RESP with err=1 and data=0. No bank access occurs.
  - RD: rd_vld_o=1 until rd_rdy_i is high, then go to RW.
  - RW: on rd_resp_vld_i, latch old data and go to EXE. rd_resp_vld_i in any other state is ignored.
  - EXE: one cycle. Drive the ALU from registers and latch the new value and the response data. Go to WR.
  - WR: wr_vld_o=1 until wr_rdy_i is high, then go to RESP.
  - RESP: resp_vld_o=1 until resp_rdy_i is high, then go to IDLE.
- Operand formation in EXE:
  - .W signed ops (ADD, MIN, MAX, logic): both operands are sign-extended from bit 31.
  - .W unsigned ops (MINU, MAXU): both operands are zero-extended.
- ALU opcode mapping: ADD→ALU_ADD, with alu_op_w_o=req_op_w. XOR/AND/OR→ALU_XOR/ALU_AND/ALU_OR. MIN/MAX→ALU_SLT. MINU/MAXU→ALU_SLTU. SWAP uses no ALU; new value = rs2.
- MIN/MAX select: lt = alu_result_i[0], meaning old < rs2. MIN/MINU new value = lt ? old : rs2. MAX/MAXU new value = lt ? rs2 : old.
- For .W, the new value is truncated to [31:0] and zero-filled above.
- ALU outputs outside EXE: opcode=ALU_ADD, op_w=0, operands=0.
- Exactly one AMO is in flight. req_rdy_o is low in every state except IDLE.

## Timing
- Reset values: req_rdy_o=1; all other outputs 0. Reset mid-operation abandons the AMO; no write or response is issued after reset.
- Minimum latency (rd_rdy_i, rd_resp_vld_i, wr_rdy_i and resp_rdy_i all immediate):
  - accept at cycle 0
  - rd_vld_o at cycle 1
  - rd_resp_vld_i sampled at cycle 2
  - EXE at cycle 3
  - wr_vld_o at cycle 4
  - resp_vld_o at cycle 5
  - next accept possible at cycle 6
- Illegal op: resp_vld_o asserts the cycle after accept.
- All valid outputs hold with stable payload until their ready. Payload comes from registers; there is no combinational ready-to-valid path.

## Configuration
- RVH_L1D_AMO_MINMAX_EN
  - Defined: MIN, MAX, MINU and MAXU are supported as described.
  - Undefined: ops 5–8 are treated as illegal (err=1, no bank access) and the SLT select logic is not built.

## Test plan
- ADD.D, old=0x0000_0000_0000_0005, rs2=0x3 → wr_data=0x8, resp_data=0x5, resp_vld_o at cycle 5.
- ADD.W, old=0x7FFF_FFFF, rs2=0x1 → wr_data=0x0000_0000_8000_0000, resp_data=0x0000_0000_7FFF_FFFF. With old=0xFFFF_FFFF, resp_data=0xFFFF_FFFF_FFFF_FFFF.
- MIN.D, old=0xFFFF_FFFF_FFFF_FFFE, rs2=0x1 → wr_data=old. MINU.D with the same operands → wr_data=0x1. With the macro undefined, both give err=1 and wr_vld_o is never asserted.
- SWAP.D with rd_rdy_i stalled 3 cycles, wr_rdy_i stalled 2 cycles and resp_rdy_i stalled 4 cycles → rd_vld_o, wr_vld_o and resp_vld_o each hold their payload stable; wr_data=rs2; id is echoed.
- op=12 → resp_err_o=1 and resp_data=0 at cycle 1; rd_vld_o and wr_vld_o stay 0.
- rst asserted while in WR → all outputs return to reset values; wr_vld_o and resp_vld_o are not asserted after rst releases; the next request completes normally.
